uart_cmd_responder: RTL and testbench

DUT-side end of the remote command link. Receives 16-bit commands as two 8N1 UART bytes (high byte first) from the remote controller, presents them to the command processor as a single word with a ready flag, and transmits 8-bit response bytes (e.g. positive acknowledge 0xA5) back over the same link. Contains its own UART receive and transmit engines; sits between the `RX`/`TX` pins and the command processor inside `KnightsTour`.

---
 rtl/uart_cmd_responder.sv | 207 ++++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// Remote command link endpoint: two-byte UART command receiver plus single-byte response transmitter.
// Optional inter-byte timeout on the command byte order is built when CMD_TIMEOUT_EN is defined.
module uart_cmd_responder #(
    parameter int BAUD_CYCLES    = 5208,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent
);

    localparam int CW = $clog2(BAUD_CYCLES);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_CYCLES / 2 - 1);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {ORD_HIGH, ORD_LOW} ord_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

    // ---------------- RX synchronizer and edge detect ----------------
    logic rx_s1, rx_s2, rx_prev;
    logic rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;

    // ---------------- RX engine ----------------
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [3:0]      rx_idx;     // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]      rx_shift;
    logic            rx_tick;
    logic            byte_good;

    assign rx_tick   = (rx_state == RX_RECV) && (rx_cnt == '0);
    assign byte_good = rx_tick && (rx_idx == 4'd9) && rx_s2;

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: if (rx_fall) rx_next = RX_RECV;
            RX_RECV: begin
                // A high start sample is a glitch; the stop sample always ends the frame.
                if (rx_tick && ((rx_idx == 4'd0 && rx_s2) || rx_idx == 4'd9))
                    rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt   <= '0;
            rx_idx   <= 4'd0;
            rx_shift <= 8'h00;
        end else if (rx_state == RX_IDLE) begin
            if (rx_fall) begin
                rx_cnt <= HALF_LAST;
                rx_idx <= 4'd0;
            end
        end else if (rx_cnt == '0) begin
            rx_cnt <= BAUD_LAST;
            rx_idx <= rx_idx + 4'd1;
            if (rx_idx >= 4'd1 && rx_idx <= 4'd8)
                rx_shift <= {rx_s2, rx_shift[7:1]};
        end else begin
            rx_cnt <= rx_cnt - 1'b1;
        end
    end

    // ---------------- Byte-order FSM and command register ----------------
    ord_state_t ord_state, ord_next;
    logic [7:0] hi_reg;
    logic       to_expired;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || ord_state == ORD_HIGH || byte_good) to_cnt <= '0;
        else                                           to_cnt <= to_cnt + 1'b1;
    end

    assign to_expired = (ord_state == ORD_LOW) && (to_cnt == TO_LAST);
`else
    // Without the timeout, LOW waits indefinitely for the second byte.
    assign to_expired = 1'b0;
    if (TIMEOUT_CYCLES > 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) ord_state <= ORD_HIGH;
        else     ord_state <= ord_next;
    end

    always_comb begin
        ord_next = ord_state;
        case (ord_state)
            ORD_HIGH: if (byte_good) ord_next = ORD_LOW;
            ORD_LOW:  if (byte_good || to_expired) ord_next = ORD_HIGH;
            default:  ord_next = ORD_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg  <= 8'h00;
            cmd     <= 16'h0000;
            cmd_rdy <= 1'b0;
        end else begin
            if (byte_good && ord_state == ORD_HIGH)
                hi_reg <= rx_shift;
            if (byte_good && ord_state == ORD_LOW) begin
                cmd     <= {hi_reg, rx_shift};
                cmd_rdy <= 1'b1;     // completion wins over a coincident clear
            end else if (clr_cmd_rdy || (byte_good && ord_state == ORD_HIGH)) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    // ---------------- TX engine ----------------
    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_idx;       // bit currently on the line: 0 = start, 1..8 = data, 9 = stop
    logic [7:0]    tx_data;
    logic          tx_reg;
    logic          tx_tick;

    assign tx_tick = (tx_state == TX_XMIT) && (tx_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (send_resp) tx_next = TX_XMIT;
            TX_XMIT: if (tx_tick && tx_idx == 4'd9) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg    <= 1'b1;
            resp_sent <= 1'b0;
            tx_cnt    <= '0;
            tx_idx    <= 4'd0;
            tx_data   <= 8'h00;
        end else begin
            resp_sent <= 1'b0;
            if (tx_state == TX_IDLE) begin
                if (send_resp) begin
                    tx_data <= resp;
                    tx_reg  <= 1'b0;
                    tx_cnt  <= BAUD_LAST;
                    tx_idx  <= 4'd0;
                end
            end else if (tx_cnt == '0) begin
                if (tx_idx == 4'd9) begin
                    tx_reg    <= 1'b1;
                    resp_sent <= 1'b1;
                end else begin
                    tx_idx <= tx_idx + 4'd1;
                    tx_cnt <= BAUD_LAST;
                    tx_reg <= (tx_idx == 4'd8) ? 1'b1 : tx_data[tx_idx[2:0]];
                end
            end else begin
                tx_cnt <= tx_cnt - 1'b1;
            end
        end
    end

    assign TX      = tx_reg;
    assign tx_busy = (tx_state == TX_XMIT);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder at BAUD_CYCLES=16, TIMEOUT_CYCLES=400.
module tb_uart_cmd_responder;
    localparam int BAUD = 16;
    localparam int TOUT = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        tx;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        tx_busy;
    logic        resp_sent;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_cmd_responder #(.BAUD_CYCLES(BAUD), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .rst(rst), .RX(rx), .TX(tx), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .tx_busy(tx_busy), .resp_sent(resp_sent)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit plus 8 data bits, LSB first.
    task automatic uart_body(input logic [7:0] b);
        rx = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BAUD);
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        uart_body(b);
        rx = stop;
        tick(BAUD);
        rx = 1'b1;
        tick(4);
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
        tick(3);
        tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b expected 1", tx); end
        tests_run++; if (cmd !== 16'h0000) begin tests_failed++; $display("FAIL reset_cmd: got %h expected 0000", cmd); end
        tests_run++; if (cmd_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
        tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        tests_run++; if (resp_sent !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_sent: got %b expected 0", resp_sent); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_cmd_receive;
        uart_send(8'h70, 1'b1);
        uart_body(8'h04);
        rx = 1'b1;
        tick(10);   // one cycle before the stop-sample result is visible
        tests_run++; if (cmd_rdy !== 1'b0) begin tests_failed++; $display("FAIL rdy_early: got %b expected 0", cmd_rdy); end
        tick(1);
        tests_run++; if (cmd_rdy !== 1'b1) begin tests_failed++; $display("FAIL rdy_on_time: got %b expected 1", cmd_rdy); end
        tests_run++; if (cmd !== 16'h7004) begin tests_failed++; $display("FAIL cmd_7004: got %h expected 7004", cmd); end
        tick(9);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        tests_run++; if (cmd_rdy !== 1'b0) begin tests_failed++; $display("FAIL clr_rdy: got %b expected 0", cmd_rdy); end
        tests_run++; if (cmd !== 16'h7004) begin tests_failed++; $display("FAIL cmd_hold: got %h expected 7004", cmd); end
    endtask

    task automatic test_response_tx;
        logic frame [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        resp = 8'hA5;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        for (int c = 1; c <= 175; c++) begin
            if (c % 16 == 8 && c <= 152) begin
                tests_run++;
                if (tx !== frame[(c - 8) / 16]) begin
                    tests_failed++;
                    $display("FAIL tx_bit%0d: got %b expected %b", (c - 8) / 16, tx, frame[(c - 8) / 16]);
                end
            end
            if (c == 1 || c == 50 || c == 160 || c == 161 || c == 175) begin
                tests_run++;
                if (tx_busy !== (c <= 160)) begin
                    tests_failed++;
                    $display("FAIL tx_busy_c%0d: got %b expected %b", c, tx_busy, (c <= 160));
                end
            end
            if (c >= 159 && c <= 163) begin
                tests_run++;
                if (resp_sent !== (c == 161)) begin
                    tests_failed++;
                    $display("FAIL resp_sent_c%0d: got %b expected %b", c, resp_sent, (c == 161));
                end
            end
            if (c == 175) begin
                tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL tx_idle_after: got %b expected 1", tx); end
            end
            send_resp = (c == 50);
            resp      = (c == 50) ? 8'hFF : 8'hA5;
            tick(1);
        end
        send_resp = 1'b0;
    endtask

    task automatic test_framing_error;
        uart_send(8'h12, 1'b0);
        uart_send(8'h34, 1'b1);
        uart_send(8'h56, 1'b1);
        tests_run++; if (cmd !== 16'h3456) begin tests_failed++; $display("FAIL framing_cmd: got %h expected 3456", cmd); end
        tests_run++; if (cmd_rdy !== 1'b1) begin tests_failed++; $display("FAIL framing_rdy: got %b expected 1", cmd_rdy); end
    endtask

    task automatic test_simultaneous;
        uart_send(8'h12, 1'b1);
        tests_run++; if (cmd_rdy !== 1'b0) begin tests_failed++; $display("FAIL high_clears_rdy: got %b expected 0", cmd_rdy); end
        uart_body(8'h34);
        rx = 1'b1;
        tick(10);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        tests_run++; if (cmd_rdy !== 1'b1) begin tests_failed++; $display("FAIL simul_rdy: got %b expected 1", cmd_rdy); end
        tests_run++; if (cmd !== 16'h1234) begin tests_failed++; $display("FAIL simul_cmd: got %h expected 1234", cmd); end
        tick(9);
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
        uart_send(8'hBE, 1'b1);
        uart_send(8'hEF, 1'b1);
        tests_run++; if (cmd !== 16'hBEEF) begin tests_failed++; $display("FAIL glitch_cmd: got %h expected beef", cmd); end
    endtask

    task automatic test_reset_mid;
        uart_send(8'h99, 1'b1);
        resp = 8'h5A;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        tick(19);   // cycle 20: data bit 0 of 0x5A on the line
        tests_run++; if (tx !== 1'b0) begin tests_failed++; $display("FAIL tx_before_rst: got %b expected 0", tx); end
        rst = 1'b1;
        tick(1);
        tests_run++; if (tx !== 1'b1) begin tests_failed++; $display("FAIL tx_after_rst: got %b expected 1", tx); end
        tests_run++; if (tx_busy !== 1'b0) begin tests_failed++; $display("FAIL busy_after_rst: got %b expected 0", tx_busy); end
        tests_run++; if (cmd !== 16'h0000) begin tests_failed++; $display("FAIL cmd_after_rst: got %h expected 0000", cmd); end
        rst = 1'b0;
        tick(2);
        uart_send(8'hAB, 1'b1);
        uart_send(8'hCD, 1'b1);
        tests_run++; if (cmd !== 16'hABCD) begin tests_failed++; $display("FAIL rst_cmd: got %h expected abcd", cmd); end
        tests_run++; if (cmd_rdy !== 1'b1) begin tests_failed++; $display("FAIL rst_rdy: got %b expected 1", cmd_rdy); end
    endtask

    task automatic test_timeout;
        logic [15:0] exp_cmd;
`ifdef CMD_TIMEOUT_EN
        exp_cmd = 16'h2233;
`else
        exp_cmd = 16'h1122;
`endif
        uart_send(8'h11, 1'b1);
        tick(500);
        uart_send(8'h22, 1'b1);
        uart_send(8'h33, 1'b1);
        tests_run++; if (cmd !== exp_cmd) begin tests_failed++; $display("FAIL timeout_cmd: got %h expected %h", cmd, exp_cmd); end
    endtask

    initial begin
        test_reset();
        test_cmd_receive();
        test_response_tx();
        test_framing_error();
        test_simultaneous();
        test_glitch();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
